// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin bus arbiter with target handshake, single data strobe and per-grant timeout.
module bus_rr_arbiter #(
    parameter int DEVICE_MAX_NUMBER = 4,
    parameter int CLK_MAX_TIMEOUT   = 10,
    parameter int IDX_W             = $clog2(DEVICE_MAX_NUMBER),
    parameter int TO_W              = $clog2(CLK_MAX_TIMEOUT + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DEVICE_MAX_NUMBER-1:0] barq_i,
    output logic [DEVICE_MAX_NUMBER-1:0] bagd_o,
    output logic                         target_ready_o,
    input  logic                         address_valid_i,
    output logic                         data_strobe_o,
    output logic                         error_o,
    output logic [DEVICE_MAX_NUMBER-1:0] err_master_o,
    input  logic                         err_clr_i,
    output logic [IDX_W-1:0]             grant_idx_o,
    output logic                         busy_o
);
    typedef enum logic [1:0] {IDLE, GRANT, READY, RELEASE} state_t;
    state_t state, state_n;
    logic [IDX_W-1:0] ptr, win, nxt;
    logic [TO_W-1:0] cnt;
    logic s1, s2, open, strobe, timeout, start;
    always_comb begin
        win = ptr;
        for (int i = DEVICE_MAX_NUMBER - 1; i >= 0; i--)
            if (barq_i[IDX_W'((int'(ptr) + i) % DEVICE_MAX_NUMBER)])
                win = IDX_W'((int'(ptr) + i) % DEVICE_MAX_NUMBER);
    end
    assign nxt     = IDX_W'((int'(grant_idx_o) + 1) % DEVICE_MAX_NUMBER);
    assign open    = state == GRANT || state == READY;
    assign start   = state == IDLE && |barq_i;
    assign strobe  = state == READY && s1 && !s2;
    // a strobe on the timeout edge completes the transfer, so it masks the error
    assign timeout = open && cnt == TO_W'(CLK_MAX_TIMEOUT) && !strobe;
    assign busy_o  = state != IDLE;
    always_comb begin
        state_n = state;
        if (start) state_n = GRANT;
        else if (strobe || timeout) state_n = RELEASE;
        else if (state == GRANT) state_n = READY;
        else if (state == RELEASE) state_n = IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr            <= '0;
            cnt            <= '0;
            s1             <= 1'b0;
            s2             <= 1'b0;
            bagd_o         <= '0;
            target_ready_o <= 1'b0;
            data_strobe_o  <= 1'b0;
            error_o        <= 1'b0;
            err_master_o   <= '0;
            grant_idx_o    <= '0;
        end else begin
            s1            <= state == READY && address_valid_i && target_ready_o;
            s2            <= state == READY && s1;
            data_strobe_o <= strobe;
            error_o       <= timeout;
            err_master_o  <= (err_clr_i ? '0 : err_master_o)
                           | (timeout ? DEVICE_MAX_NUMBER'(1) << grant_idx_o : '0);
            if (open && cnt != TO_W'(CLK_MAX_TIMEOUT)) cnt <= cnt + 1'b1;
            if (start) begin
                bagd_o      <= DEVICE_MAX_NUMBER'(1) << win;
                grant_idx_o <= win;
                cnt         <= '0;
            end else if (strobe || timeout) begin
                bagd_o         <= '0;
                target_ready_o <= 1'b0;
                ptr            <= nxt;
            end else if (state == GRANT) begin
                target_ready_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed stimulus with a queue scoreboard of expected grant/strobe/error events.
module tb_bus_rr_arbiter;
    logic clk = 1'b0, rst = 1'b0;
    logic [3:0] barq = '0, bagd, err_master;
    logic av = 1'b0, err_clr = 1'b0;
    logic tr, strobe, error, busy;
    logic [1:0] gidx;
    logic [3:0] prev_bagd = '0;
    int cyc = 0, nt = 0, nf = 0;
    typedef struct {int kind; int data; int cyc;} ev_t;
    ev_t q[$];

    bus_rr_arbiter dut (
        .clk(clk), .rst(rst), .barq_i(barq), .bagd_o(bagd), .target_ready_o(tr),
        .address_valid_i(av), .data_strobe_o(strobe), .error_o(error),
        .err_master_o(err_master), .err_clr_i(err_clr), .grant_idx_o(gidx), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        nt++;
        if (act != exp) begin
            nf++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int data, input int c);
        ev_t e;
        e.kind = kind; e.data = data; e.cyc = c;
        q.push_back(e);
    endtask

    // kind 0 = new grant (idx*16+bagd), 1 = data strobe, 2 = timeout error (err_master)
    task automatic got(input int kind, input int data);
        ev_t e;
        nt++;
        if (q.size() == 0) begin
            nf++;
            $display("FAIL event: unexpected kind %0d data %0d at cycle %0d", kind, data, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.data != data || e.cyc != cyc) begin
                nf++;
                $display("FAIL event: got kind %0d data %0d cycle %0d expected kind %0d data %0d cycle %0d",
                         kind, data, cyc, e.kind, e.data, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bagd != 0 && prev_bagd == 0) got(0, int'(gidx) * 16 + int'(bagd));
            if (strobe) got(1, 0);
            if (error) got(2, int'(err_master));
        end
        prev_bagd <= bagd;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic [3:0] req, input logic [3:0] rq2, input int k, input int av_len,
                       input int eb, input int ei);
        int t0;
        t0 = cyc;
        barq = req;
        push(0, ei * 16 + eb, t0 + 1);
        step(2);
        barq = rq2;
        chk("target_ready", int'(tr), 1);
        step(k - 2);
        av = 1'b1;
        push(1, 0, t0 + k + 2);
        while (cyc < t0 + k + 3 || av) begin
            step(1);
            if (cyc == t0 + k + av_len) av = 1'b0;
            if (cyc == t0 + k + 2) begin
                chk("bagd_at_strobe", int'(bagd), 0);
                chk("tr_at_strobe", int'(tr), 0);
            end
        end
    endtask

    initial begin
        int t0;
        #2 rst = 1'b1;
        step(2);
        chk("rst_bagd", int'(bagd), 0);
        chk("rst_tr", int'(tr), 0);
        chk("rst_strobe", int'(strobe), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_err_master", int'(err_master), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_gidx", int'(gidx), 0);
        rst = 1'b0;
        step(1);
        // rotation with all masters requesting
        txn(4'b1111, 4'b1111, 2, 2, 4'b0001, 0);
        txn(4'b1111, 4'b1111, 2, 2, 4'b0010, 1);
        txn(4'b1111, 4'b1111, 2, 2, 4'b0100, 2);
        txn(4'b1111, 4'b1111, 2, 2, 4'b1000, 3);
        txn(4'b1111, 4'b0000, 2, 2, 4'b0001, 0);
        barq = '0;
        step(1);
        // single request, ptr now 1
        txn(4'b0001, 4'b0000, 2, 2, 4'b0001, 0);
        chk("gidx_hold", int'(gidx), 0);
        chk("idle_busy", int'(busy), 0);
        // timeout for master 2
        t0 = cyc;
        barq = 4'b0100;
        push(0, 2 * 16 + 4, t0 + 1);
        push(2, 4, t0 + 12);
        step(2);
        barq = '0;
        step(10);
        chk("timeout_bagd", int'(bagd), 0);
        chk("timeout_err_master", int'(err_master), 4);
        step(2);
        chk("timeout_busy", int'(busy), 0);
        // strobe coincides with cnt reaching the limit, ptr now 3
        txn(4'b1000, 4'b0000, 10, 2, 4'b1000, 3);
        chk("coincide_err_master", int'(err_master), 4);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        chk("err_clr", int'(err_master), 0);
        // request dropped in READY, address valid held long, ptr now 0
        txn(4'b0010, 4'b0000, 2, 6, 4'b0010, 1);
        step(1);
        // reset mid grant, ptr now 2
        t0 = cyc;
        barq = 4'b0100;
        push(0, 2 * 16 + 4, t0 + 1);
        step(3);
        rst = 1'b1;
        barq = '0;
        #1;
        chk("midrst_bagd", int'(bagd), 0);
        chk("midrst_tr", int'(tr), 0);
        chk("midrst_strobe", int'(strobe), 0);
        chk("midrst_busy", int'(busy), 0);
        step(1);
        rst = 1'b0;
        step(1);
        txn(4'b1001, 4'b0000, 2, 2, 4'b0001, 0);
        step(3);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end
endmodule
